trivium_out_fifo: RTL and testbench
===================================

# trivium_out_fifo

Output buffer directly downstream of the Trivium cipher core. It captures encrypted bytes written by the core (`stream` qualified by `wt_sgn`) and holds them until the host-side reader drains them. It reports fill status back to the core on `fifo_cnd`, which the core uses to decide whether it may start the next 256-byte burst. It also detects and flags overflow.

## Interface
- `DEPTH`, 512: storage depth in bytes; power of two, ≥ 2·`BURST`.
- `BURST`, 256: cipher burst length in bytes; threshold used for `fifo_cnd`.
- `AW`, $clog2(`DEPTH`): pointer width (derived, not overridden).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write strobe; connects to the core's `wt_sgn`.
- `wr_data` in 8: byte to store; connects to the core's `stream`.
- `rd_en` in 1: read request from the host side.
- `clr` in 1: synchronous flush.
- `rd_data` out 8: read byte, registered.
- `rd_valid` out 1: `rd_data` holds a newly read byte (1-cycle pulse per read).
- `count` out AW+1: bytes currently stored, 0..`DEPTH`.
- `fifo_cnd` out 2: status to the core's `fifo_cnd`.
- `ovf` out 1: sticky overflow flag.

## Operation
- Storage is a circular buffer of `DEPTH`×8 with write pointer `wp` and read pointer `rp`, each AW bits.
- Pointers wrap modulo `DEPTH`. `count` is tracked explicitly (AW+1 bits) to distinguish full from empty.
- Write is accepted when `wr_en`=1 and (`count` < `DEPTH`, or a read is accepted in the same cycle).
  - On accept: mem[`wp`] ← `wr_data`, then `wp`+1.
- Write with `wr_en`=1 when full and no read accepted: byte dropped, `ovf` ← 1. Pointers and memory are unchanged.
- Read is accepted when `rd_en`=1 and `count` > 0.
  - On accept: `rd_data` ← mem[`rp`], `rp`+1, `rd_valid` ← 1.
- Read with `rd_en`=1 when empty: ignored, `rd_valid` ← 0, no error.
- There is no write-to-read bypass. A read and a write in the same cycle on an empty FIFO accepts the write only.
- `count` update per cycle: +1 for write only, −1 for read only, unchanged for both or neither.
- `fifo_cnd` is combinational from registered state, in priority order:
  - 2'b11 if `ovf`=1;
  - 2'b10 if `count`==`DEPTH`;
  - 2'b01 if `DEPTH`−`count` < `BURST`;
  - 2'b00 otherwise (room for one full burst).
- `ovf` is sticky. It clears only on `rst` or `clr`.
- `clr`=1: `wp`, `rp`, `count` ← 0; `ovf` ← 0; `rd_valid` ← 0.
  - `clr` overrides `wr_en`/`rd_en` in the same cycle; both are discarded.
  - Memory contents are not cleared.

## Timing
- Reset values (asynchronous on `rst` low): `rd_data`=0, `rd_valid`=0, `count`=0, `ovf`=0, `fifo_cnd`=2'b00, `wp`=`rp`=0. Memory is not reset.
- Reset mid-burst aborts everything. No state survives; the first edge after `rst` rises behaves as from empty.
- Write at edge k: `count` and `fifo_cnd` reflect it after edge k.
- Read at edge k: `rd_data`/`rd_valid` are valid after edge k (1-cycle latency). `rd_valid` drops after edge k+1 unless another read is accepted.
- Sustained throughput is one write and one read per cycle.
- The core samples `fifo_cnd` only in its Secret_Ready state. The core may begin a new 256-byte burst only when `fifo_cnd`==2'b00, which guarantees no overflow during that burst even with zero reads.
- Overflow sets `ovf` on the same edge as the dropped write, so `fifo_cnd`=2'b11 from the next cycle.

## Test plan
- Reset, then 256 consecutive writes of bytes 0x00..0xFF with no reads → `count`=256, `fifo_cnd`=2'b00, `ovf`=0. One more write (0xA5) → `count`=257, `fifo_cnd`=2'b01.
- From empty, 512 writes (i mod 256) → `count`=512, `fifo_cnd`=2'b10. Write 0x77 → dropped, `ovf`=1, `fifo_cnd`=2'b11, `count`=512. Drain all 512 → data 0x00..0xFF twice (no 0x77), `fifo_cnd` stays 2'b11 until `clr`.
- Full FIFO with `wr_en`=`rd_en`=1 for 10 cycles → `count` stays 512, `ovf`=0, reads return the oldest bytes in order.
- Empty FIFO, `wr_en`=1 (0x3C) and `rd_en`=1 in the same cycle → `rd_valid`=0, `count`=1. `rd_en` on the next cycle → `rd_data`=0x3C, `rd_valid`=1.
- Pointer wrap: 3 rounds of 400 writes then 400 reads with an incrementing pattern → every byte is read back in order, `count` returns to 0, `ovf`=0.
- Mid-operation: 100 writes, then `clr` together with `wr_en`=1 → `count`=0, `fifo_cnd`=2'b00, byte discarded. Async `rst` pulse mid-read-stream → all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/trivium_out_fifo_if.sv
// Host/core-facing bus of the Trivium output FIFO.
// The master drives writes, reads and flush; the slave (the FIFO) returns data and status.
interface trivium_out_fifo_if #(
  parameter int unsigned DEPTH = 512
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic          clr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic [1:0]    fifo_cnd;
  logic          ovf;

  modport master (
    output wr_en, wr_data, rd_en, clr,
    input  rd_data, rd_valid, count, fifo_cnd, ovf
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr,
    output rd_data, rd_valid, count, fifo_cnd, ovf
  );
endinterface

// File: rtl/trivium_out_fifo.sv
// Circular byte buffer behind the Trivium core: explicit fill count, sticky overflow,
// and a burst-room status code the core checks before starting each burst.
module trivium_out_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned BURST = 256
) (
  input logic              clk,
  input logic              rst,
  trivium_out_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_drop;
  logic [CW-1:0] w_free;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A read frees a slot this cycle, so a full FIFO still takes a simultaneous write.
  assign w_rd_acc = bus.rd_en && !w_empty && !bus.clr;
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc) && !bus.clr;
  assign w_drop   = bus.wr_en && w_full && !w_rd_acc && !bus.clr;
  assign w_free   = CW'(DEPTH) - r_count;

  // Storage has no reset; contents are only meaningful between rp and wp.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wp] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.clr) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + AW'(1);
      if (w_rd_acc) begin
        r_rp      <= r_rp + AW'(1);
        r_rd_data <= r_mem[r_rp];
      end
      r_rd_valid <= w_rd_acc;
      if (w_drop) r_ovf <= 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
    end
  end

  // Status priority: overflow, full, less than one burst of room, room for a burst.
  always_comb begin
    bus.fifo_cnd = 2'b00;
    if (r_ovf)                        bus.fifo_cnd = 2'b11;
    else if (w_full)                  bus.fifo_cnd = 2'b10;
    else if (w_free < CW'(BURST))     bus.fifo_cnd = 2'b01;
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.count    = r_count;
  assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_trivium_out_fifo.sv
// Directed bench for trivium_out_fifo: fill/status thresholds, overflow, full-FIFO
// pass-through, empty read/write corner, pointer wrap, flush and async reset.
module tb_trivium_out_fifo;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned BURST = 256;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  trivium_out_fifo_if #(.DEPTH(DEPTH)) bus ();

  trivium_out_fifo #(.DEPTH(DEPTH), .BURST(BURST)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.rd_en   = 1'b0;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic flush();
    idle();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.wr_data = 8'h00;
    idle();
    rst = 1'b0;
    #12;
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
    chk("rst_ovf",      32'(bus.ovf),      32'd0);
    chk("rst_cnd",      32'(bus.fifo_cnd), 32'd0);
    rst = 1'b1;
    tick();

    // 256 writes leave exactly one burst of room; one more drops below it
    for (int i = 0; i < 256; i++) wr(8'(i));
    chk("t1_count", 32'(bus.count),    32'd256);
    chk("t1_cnd",   32'(bus.fifo_cnd), 32'b00);
    chk("t1_ovf",   32'(bus.ovf),      32'd0);
    wr(8'hA5);
    chk("t1_count257", 32'(bus.count),    32'd257);
    chk("t1_cnd257",   32'(bus.fifo_cnd), 32'b01);
    flush();
    chk("t1_clr_count", 32'(bus.count), 32'd0);

    // Fill, overflow, drain
    for (int i = 0; i < 512; i++) wr(8'(i));
    chk("t2_count_full", 32'(bus.count),    32'd512);
    chk("t2_cnd_full",   32'(bus.fifo_cnd), 32'b10);
    wr(8'h77);
    chk("t2_count_ovf", 32'(bus.count),    32'd512);
    chk("t2_ovf",       32'(bus.ovf),      32'd1);
    chk("t2_cnd_ovf",   32'(bus.fifo_cnd), 32'b11);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      chk("t2_drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("t2_drain_data",  32'(bus.rd_data),  32'(i % 256));
    end
    tick();
    chk("t2_empty_rd_valid", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b0;
    chk("t2_count_empty", 32'(bus.count),    32'd0);
    chk("t2_cnd_sticky",  32'(bus.fifo_cnd), 32'b11);
    flush();
    chk("t2_clr_ovf", 32'(bus.ovf),      32'd0);
    chk("t2_clr_cnd", 32'(bus.fifo_cnd), 32'b00);

    // Full FIFO with simultaneous read and write streams through
    for (int i = 0; i < 512; i++) wr(8'(i));
    for (int j = 0; j < 10; j++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hC0 + 8'(j);
      bus.rd_en   = 1'b1;
      tick();
      chk("t3_data",  32'(bus.rd_data),  32'(j));
      chk("t3_valid", 32'(bus.rd_valid), 32'd1);
      chk("t3_count", 32'(bus.count),    32'd512);
      chk("t3_ovf",   32'(bus.ovf),      32'd0);
    end
    flush();

    // Empty FIFO: same-cycle write and read accepts only the write
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3C;
    bus.rd_en   = 1'b1;
    tick();
    chk("t4_rd_valid0", 32'(bus.rd_valid), 32'd0);
    chk("t4_count1",    32'(bus.count),    32'd1);
    bus.wr_en = 1'b0;
    tick();
    chk("t4_rd_data",   32'(bus.rd_data),  32'h3C);
    chk("t4_rd_valid1", 32'(bus.rd_valid), 32'd1);
    chk("t4_count0",    32'(bus.count),    32'd0);
    idle();
    tick();
    chk("t4_valid_drop", 32'(bus.rd_valid), 32'd0);

    // Pointer wrap over three rounds of 400
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 400; i++) wr(8'(r * 400 + i));
      bus.rd_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
        tick();
        chk("t5_data", 32'(bus.rd_data), 32'((r * 400 + i) % 256));
      end
      bus.rd_en = 1'b0;
      tick();
      chk("t5_count", 32'(bus.count), 32'd0);
      chk("t5_ovf",   32'(bus.ovf),   32'd0);
    end

    // Flush with a concurrent write discards that write
    for (int i = 0; i < 100; i++) wr(8'(i + 1));
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    bus.clr     = 1'b1;
    tick();
    idle();
    chk("t6_clr_count", 32'(bus.count),    32'd0);
    chk("t6_clr_cnd",   32'(bus.fifo_cnd), 32'b00);
    bus.rd_en = 1'b1;
    tick();
    chk("t6_clr_discard", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b0;

    // Async reset in the middle of a read stream
    for (int i = 0; i < 10; i++) wr(8'h80 + 8'(i));
    bus.rd_en = 1'b1;
    tick();
    tick();
    chk("t6_pre_rst_data", 32'(bus.rd_data), 32'h81);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("t6_rst_data",  32'(bus.rd_data),  32'd0);
    chk("t6_rst_count", 32'(bus.count),    32'd0);
    chk("t6_rst_cnd",   32'(bus.fifo_cnd), 32'b00);
    idle();
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    chk("t6_post_rst_empty", 32'(bus.rd_valid), 32'd0);
    wr(8'h5A);
    bus.rd_en = 1'b1;
    tick();
    chk("t6_post_rst_data", 32'(bus.rd_data), 32'h5A);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
